// File: rtl/rom_stream_loader.sv
// CPU-fed ROM stream loader: buffers 32-bit words written by the softcore and
// serialises them to the core loader in OUT_W-bit beats with pacing and backpressure.
module rom_stream_loader #(
   parameter int OUT_W = 8,
   parameter int DEPTH = 4,
   parameter int DELAY = 12
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               reg_data_we,
   input  logic [31:0]        reg_data_di,
   input  logic [3:0]         reg_data_wstrb,
   output logic               reg_data_wait,
   input  logic               reg_ctrl_we,
   input  logic [2:0]         reg_ctrl_di,
   output logic               reg_ctrl_wait,
   output logic [2:0]         rom_loading,
   output logic [OUT_W-1:0]   rom_do,
   output logic [OUT_W/8-1:0] rom_be,
   output logic               rom_do_valid,
   input  logic               rom_ready,
   output logic               busy,
   output logic [31:0]        byte_count
);
   // state  | meaning
   // S_IDLE | serializer empty, pops the FIFO as soon as it holds a word
   // S_EMIT | shift register holds bytes; beats fire on rom_ready && delay_cnt==0

   localparam int BPB = OUT_W / 8;
   localparam int AW  = $clog2(DEPTH);
   localparam int CW  = (DELAY > 1) ? $clog2(DELAY) : 1;
   localparam logic [CW-1:0] DELAY_RELOAD = CW'(DELAY - 1);
   localparam logic [2:0]    BPB_BYTES    = 3'(BPB);
   localparam logic [AW:0]   FIFO_FULL    = (AW + 1)'(DEPTH);

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_EMIT = 1'b1
   } state_t;

   state_t          state;
   logic [31:0]     fifo_data [DEPTH];
   logic [2:0]      fifo_nb   [DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic [AW:0]     fifo_count;
   logic            fifo_empty;
   logic            fifo_full;
   logic            push;
   logic            pop;
   logic            beat;
   logic            last_beat;
   logic            ctrl_accept;
   logic [2:0]      wr_nbytes;
   logic [31:0]     shift_reg;
   logic [2:0]      rem_bytes;
   logic [CW-1:0]   delay_cnt;
   logic [OUT_W-1:0] beat_do;
   logic [BPB-1:0]  beat_be;
   logic [2:0]      beat_bytes;

   assign fifo_empty    = (fifo_count == '0);
   assign fifo_full     = (fifo_count == FIFO_FULL);
   // wait derives from registered occupancy only, so a full FIFO never accepts
   // a write in the same cycle that frees a slot
   assign reg_data_wait = fifo_full && (rom_loading != 3'd0);
   assign push          = reg_data_we && (|reg_data_wstrb) && !reg_data_wait
                          && (rom_loading != 3'd0);
   assign beat          = (state == S_EMIT) && rom_ready && (delay_cnt == '0);
   assign last_beat     = beat && (rem_bytes <= BPB_BYTES);
   assign pop           = !fifo_empty && ((state == S_IDLE) || last_beat);
   assign busy          = !fifo_empty || (state == S_EMIT) || rom_do_valid;
   assign reg_ctrl_wait = busy;
   assign ctrl_accept   = reg_ctrl_we && !busy;

   // byte count is set by the highest strobe; clear lanes below it still count
   always_comb begin
      wr_nbytes = 3'd1;
      if (reg_data_wstrb[3])      wr_nbytes = 3'd4;
      else if (reg_data_wstrb[2]) wr_nbytes = 3'd3;
      else if (reg_data_wstrb[1]) wr_nbytes = 3'd2;
   end

   always_comb begin
      beat_do    = '0;
      beat_be    = '0;
      beat_bytes = 3'd0;
      for (int i = 0; i < BPB; i++) begin
         if (3'(i) < rem_bytes) begin
            beat_do[i*8 +: 8] = shift_reg[i*8 +: 8];
            beat_be[i]        = 1'b1;
            beat_bytes        = beat_bytes + 3'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_data[wr_ptr] <= reg_data_di;
         fifo_nb[wr_ptr]   <= wr_nbytes;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + 1'b1;
            2'b01:   fifo_count <= fifo_count - 1'b1;
            default: fifo_count <= fifo_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= S_IDLE;
         shift_reg    <= '0;
         rem_bytes    <= 3'd0;
         delay_cnt    <= '0;
         rom_do       <= '0;
         rom_be       <= '0;
         rom_do_valid <= 1'b0;
         rom_loading  <= 3'd0;
         byte_count   <= '0;
      end else begin
         rom_do_valid <= beat;
         if (delay_cnt != '0) delay_cnt <= delay_cnt - 1'b1;
         if (beat) begin
            rom_do     <= beat_do;
            rom_be     <= beat_be;
            delay_cnt  <= DELAY_RELOAD;
            shift_reg  <= shift_reg >> OUT_W;
            rem_bytes  <= (rem_bytes > BPB_BYTES) ? rem_bytes - BPB_BYTES : 3'd0;
            byte_count <= byte_count + {29'd0, beat_bytes};
         end
         // a pop on the last beat overrides the shift so words run back to back
         if (pop) begin
            shift_reg <= fifo_data[rd_ptr];
            rem_bytes <= fifo_nb[rd_ptr];
            state     <= S_EMIT;
         end else if (last_beat) begin
            state <= S_IDLE;
         end
         if (ctrl_accept) begin
            rom_loading <= reg_ctrl_di;
            byte_count  <= '0;
         end
      end
   end

endmodule

// File: tb/tb_rom_stream_loader.sv
// Bench for rom_stream_loader: an 8-bit instance (DELAY=12) and a 16-bit instance
// (DELAY=4), with expected beats queued at write time and matched against observed beats.
module tb_rom_stream_loader;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic        data_we, data_wait, ctrl_we, ctrl_wait, rvalid, ready, busy;
   logic [31:0] data_di, bcount;
   logic [3:0]  data_wstrb;
   logic [2:0]  ctrl_di, loading;
   logic [7:0]  rdo;
   logic [0:0]  rbe;

   logic        w_data_we, w_data_wait, w_ctrl_we, w_ctrl_wait, w_rvalid, w_ready, w_busy;
   logic [31:0] w_data_di, w_bcount;
   logic [3:0]  w_data_wstrb;
   logic [2:0]  w_ctrl_di, w_loading;
   logic [15:0] w_rdo;
   logic [1:0]  w_rbe;

   rom_stream_loader #(.OUT_W(8), .DEPTH(4), .DELAY(12)) u_n (
      .clk(clk), .reset(reset),
      .reg_data_we(data_we), .reg_data_di(data_di), .reg_data_wstrb(data_wstrb),
      .reg_data_wait(data_wait), .reg_ctrl_we(ctrl_we), .reg_ctrl_di(ctrl_di),
      .reg_ctrl_wait(ctrl_wait), .rom_loading(loading), .rom_do(rdo), .rom_be(rbe),
      .rom_do_valid(rvalid), .rom_ready(ready), .busy(busy), .byte_count(bcount)
   );

   rom_stream_loader #(.OUT_W(16), .DEPTH(4), .DELAY(4)) u_w (
      .clk(clk), .reset(reset),
      .reg_data_we(w_data_we), .reg_data_di(w_data_di), .reg_data_wstrb(w_data_wstrb),
      .reg_data_wait(w_data_wait), .reg_ctrl_we(w_ctrl_we), .reg_ctrl_di(w_ctrl_di),
      .reg_ctrl_wait(w_ctrl_wait), .rom_loading(w_loading), .rom_do(w_rdo), .rom_be(w_rbe),
      .rom_do_valid(w_rvalid), .rom_ready(w_ready), .busy(w_busy), .byte_count(w_bcount)
   );

   typedef struct { logic [15:0] d; logic [1:0] be; } beat_t;
   typedef struct { int cyc; logic [15:0] d; logic [1:0] be; logic bsy; logic [31:0] bc; } obs_t;

   beat_t exp_n[$];
   beat_t exp_w[$];
   obs_t  obs_n[$];
   obs_t  obs_w[$];
   int    cyc = 0;
   int    errors = 0;
   int    checks = 0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (rvalid)   obs_n.push_back('{cyc, {8'h00, rdo}, {1'b0, rbe}, busy, bcount});
      if (w_rvalid) obs_w.push_back('{cyc, w_rdo, w_rbe, w_busy, w_bcount});
   end

   initial begin
      #2000000;
      $display("FAIL watchdog expired at cycle %0d, want finish earlier", cyc);
      $fatal(1, "watchdog");
   end

   task automatic push_exp(input bit wide, input logic [31:0] d, input int nb);
      beat_t b;
      if (!wide) begin
         for (int i = 0; i < nb; i++) begin
            b.d = {8'h00, d[8*i +: 8]};
            b.be = 2'b01;
            exp_n.push_back(b);
         end
      end else begin
         for (int i = 0; i < nb; i += 2) begin
            if (i + 1 < nb) begin
               b.d = d[8*i +: 16];
               b.be = 2'b11;
            end else begin
               b.d = {8'h00, d[8*i +: 8]};
               b.be = 2'b01;
            end
            exp_w.push_back(b);
         end
      end
   endtask

   task automatic cpu_data(input bit wide, input logic [31:0] d, input logic [3:0] s);
      int n = 0;
      if (wide) begin w_data_we = 1'b1; w_data_di = d; w_data_wstrb = s; end
      else begin data_we = 1'b1; data_di = d; data_wstrb = s; end
      while ((wide ? w_data_wait : data_wait) && n < 2000) begin @(negedge clk); n++; end
      if (n >= 2000) begin
         errors++; checks++;
         $display("FAIL data_wait_timeout wait=1 after %0d cycles, want 0", n);
      end
      @(posedge clk);
      @(negedge clk);
      if (wide) w_data_we = 1'b0; else data_we = 1'b0;
   endtask

   task automatic cpu_ctrl(input bit wide, input logic [2:0] mode);
      int n = 0;
      if (wide) begin w_ctrl_we = 1'b1; w_ctrl_di = mode; end
      else begin ctrl_we = 1'b1; ctrl_di = mode; end
      while ((wide ? w_ctrl_wait : ctrl_wait) && n < 2000) begin @(negedge clk); n++; end
      if (n >= 2000) begin
         errors++; checks++;
         $display("FAIL ctrl_wait_timeout wait=1 after %0d cycles, want 0", n);
      end
      @(posedge clk);
      @(negedge clk);
      if (wide) w_ctrl_we = 1'b0; else ctrl_we = 1'b0;
   endtask

   task automatic wait_obs(input bit wide, input int n, input int limit);
      int k = 0;
      while ((wide ? obs_w.size() : obs_n.size()) < n && k < limit) begin @(posedge clk); k++; end
      if ((wide ? obs_w.size() : obs_n.size()) < n) begin
         errors++; checks++;
         $display("FAIL wait_beats got=%0d want=%0d", wide ? obs_w.size() : obs_n.size(), n);
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if ({loading, rdo, rbe, rvalid, data_wait, ctrl_wait, busy, bcount} !== '0) begin
         errors++;
         $display("FAIL reset_n got loading=%0d do=%h be=%b v=%b dw=%b cw=%b busy=%b bc=%0d want all 0",
                  loading, rdo, rbe, rvalid, data_wait, ctrl_wait, busy, bcount);
      end
      checks++;
      if ({w_loading, w_rdo, w_rbe, w_rvalid, w_data_wait, w_ctrl_wait, w_busy, w_bcount} !== '0) begin
         errors++;
         $display("FAIL reset_w got loading=%0d do=%h be=%b v=%b busy=%b bc=%0d want all 0",
                  w_loading, w_rdo, w_rbe, w_rvalid, w_busy, w_bcount);
      end
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_single();
      int t;
      obs_t o;
      beat_t e;
      cpu_ctrl(1'b0, 3'd1);
      checks++;
      if (loading !== 3'd1 || bcount !== 32'd0) begin
         errors++;
         $display("FAIL single_mode got loading=%0d bc=%0d want 1 0", loading, bcount);
      end
      push_exp(1'b0, 32'h44332211, 4);
      cpu_data(1'b0, 32'h44332211, 4'hF);
      t = cyc;
      wait_obs(1'b0, 4, 100);
      for (int i = 0; i < 4; i++) begin
         if (obs_n.size() == 0) break;
         o = obs_n.pop_front();
         e = exp_n.pop_front();
         checks++;
         if (o.d !== e.d || o.be !== e.be) begin
            errors++;
            $display("FAIL single_data%0d got %h/%b want %h/%b", i, o.d, o.be, e.d, e.be);
         end
         checks++;
         if (o.cyc !== t + 2 + 12 * i) begin
            errors++;
            $display("FAIL single_time%0d got cycle t+%0d want t+%0d", i, o.cyc - t, 2 + 12 * i);
         end
         if (i == 3) begin
            checks++;
            if (o.bsy !== 1'b1 || o.bc !== 32'd4) begin
               errors++;
               $display("FAIL single_last got busy=%b bc=%0d want 1 4", o.bsy, o.bc);
            end
         end
      end
      while (cyc < t + 39) @(negedge clk);
      checks++;
      if (busy !== 1'b0 || ctrl_wait !== 1'b0) begin
         errors++;
         $display("FAIL single_busy_fall got busy=%b cw=%b at t+%0d want 0 0", busy, ctrl_wait, cyc - t);
      end
   endtask

   task automatic test_backpressure();
      int rel;
      obs_t o;
      beat_t e;
      push_exp(1'b0, 32'hDDCCBBAA, 4);
      cpu_data(1'b0, 32'hDDCCBBAA, 4'hF);
      wait_obs(1'b0, 2, 100);
      ready = 1'b0;
      repeat (50) @(negedge clk);
      checks++;
      if (obs_n.size() != 2) begin
         errors++;
         $display("FAIL hold_no_beat got %0d beats want 2", obs_n.size());
      end
      rel = cyc;
      ready = 1'b1;
      wait_obs(1'b0, 4, 100);
      for (int i = 0; i < 4; i++) begin
         if (obs_n.size() == 0) break;
         o = obs_n.pop_front();
         e = exp_n.pop_front();
         checks++;
         if (o.d !== e.d || o.be !== e.be) begin
            errors++;
            $display("FAIL hold_data%0d got %h/%b want %h/%b", i, o.d, o.be, e.d, e.be);
         end
         if (i >= 2) begin
            checks++;
            if (o.cyc !== rel + 1 + 12 * (i - 2)) begin
               errors++;
               $display("FAIL hold_time%0d got rel+%0d want rel+%0d", i, o.cyc - rel, 1 + 12 * (i - 2));
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] d;
      int prev;
      obs_t o;
      beat_t e;
      for (int k = 0; k < 6; k++) begin
         d = 32'hA0B0C0D0 + 32'h01010101 * k;
         push_exp(1'b0, d, 4);
         cpu_data(1'b0, d, 4'hF);
         if (k == 3) begin
            checks++;
            if (data_wait !== 1'b0) begin
               errors++;
               $display("FAIL b2b_wait4 got %b want 0", data_wait);
            end
         end
         if (k == 4) begin
            checks++;
            if (data_wait !== 1'b1) begin
               errors++;
               $display("FAIL b2b_wait5 got %b want 1", data_wait);
            end
         end
      end
      wait_obs(1'b0, 24, 2000);
      prev = 0;
      for (int i = 0; i < 24; i++) begin
         if (obs_n.size() == 0) break;
         o = obs_n.pop_front();
         e = exp_n.pop_front();
         checks++;
         if (o.d !== e.d || o.be !== e.be) begin
            errors++;
            $display("FAIL b2b_data%0d got %h/%b want %h/%b", i, o.d, o.be, e.d, e.be);
         end
         if (i > 0) begin
            checks++;
            if (o.cyc - prev !== 12) begin
               errors++;
               $display("FAIL b2b_gap%0d got %0d want 12", i, o.cyc - prev);
            end
         end
         if (i == 23) begin
            checks++;
            if (o.bc !== 32'd32) begin
               errors++;
               $display("FAIL b2b_count got %0d want 32", o.bc);
            end
         end
         prev = o.cyc;
      end
   endtask

   task automatic test_ctrl_drain();
      int a;
      obs_t o;
      beat_t e;
      cpu_ctrl(1'b0, 3'd1);
      push_exp(1'b0, 32'h87654321, 4);
      cpu_data(1'b0, 32'h87654321, 4'hF);
      push_exp(1'b0, 32'h0000BEEF, 2);
      cpu_data(1'b0, 32'h0000BEEF, 4'b0010);
      checks++;
      if (ctrl_wait !== 1'b1) begin
         errors++;
         $display("FAIL drain_wait got %b want 1", ctrl_wait);
      end
      cpu_ctrl(1'b0, 3'd0);
      a = cyc;
      checks++;
      if (loading !== 3'd0 || bcount !== 32'd0) begin
         errors++;
         $display("FAIL drain_mode got loading=%0d bc=%0d want 0 0", loading, bcount);
      end
      checks++;
      if (obs_n.size() != 6) begin
         errors++;
         $display("FAIL drain_count got %0d beats want 6", obs_n.size());
      end
      for (int i = 0; i < 6; i++) begin
         if (obs_n.size() == 0) break;
         o = obs_n.pop_front();
         e = exp_n.pop_front();
         checks++;
         if (o.d !== e.d || o.be !== e.be) begin
            errors++;
            $display("FAIL drain_data%0d got %h/%b want %h/%b", i, o.d, o.be, e.d, e.be);
         end
         if (i == 5) begin
            checks++;
            if (a !== o.cyc + 2 || o.bc !== 32'd6) begin
               errors++;
               $display("FAIL drain_accept got accept=last+%0d bc=%0d want last+2 6", a - o.cyc, o.bc);
            end
         end
      end
   endtask

   task automatic test_wide();
      int t;
      int prev;
      obs_t o;
      beat_t e;
      cpu_ctrl(1'b1, 3'd4);
      push_exp(1'b1, 32'hCCBBAA99, 4);
      cpu_data(1'b1, 32'hCCBBAA99, 4'hF);
      t = cyc;
      push_exp(1'b1, 32'h00000077, 1);
      cpu_data(1'b1, 32'h00000077, 4'b0001);
      cpu_data(1'b1, 32'hFFFF0000, 4'b0000);
      push_exp(1'b1, 32'h12345678, 3);
      cpu_data(1'b1, 32'h12345678, 4'b0100);
      wait_obs(1'b1, 5, 200);
      prev = t - 2;
      for (int i = 0; i < 5; i++) begin
         if (obs_w.size() == 0) break;
         o = obs_w.pop_front();
         e = exp_w.pop_front();
         checks++;
         if (o.d !== e.d || o.be !== e.be) begin
            errors++;
            $display("FAIL wide_data%0d got %h/%b want %h/%b", i, o.d, o.be, e.d, e.be);
         end
         checks++;
         if (o.cyc - prev !== (i == 0 ? 4 : 4)) begin
            errors++;
            $display("FAIL wide_time%0d got gap %0d want 4", i, o.cyc - prev);
         end
         if (i == 2 || i == 4) begin
            checks++;
            if (o.bc !== (i == 2 ? 32'd5 : 32'd8)) begin
               errors++;
               $display("FAIL wide_count%0d got %0d want %0d", i, o.bc, i == 2 ? 5 : 8);
            end
         end
         prev = o.cyc;
      end
      checks++;
      if (obs_w.size() != 0) begin
         errors++;
         $display("FAIL wide_extra got %0d extra beats want 0", obs_w.size());
      end
   endtask

   task automatic test_reset_mid();
      int b1;
      obs_t o;
      beat_t e;
      cpu_ctrl(1'b0, 3'd1);
      push_exp(1'b0, 32'h5A6B7C8D, 4);
      cpu_data(1'b0, 32'h5A6B7C8D, 4'hF);
      wait_obs(1'b0, 1, 50);
      b1 = cyc;
      if (obs_n.size() != 0) begin
         o = obs_n.pop_front();
         e = exp_n.pop_front();
         b1 = o.cyc;
         checks++;
         if (o.d !== e.d) begin
            errors++;
            $display("FAIL rst_first got %h want %h", o.d, e.d);
         end
      end
      while (cyc < b1 + 11) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      checks++;
      if (loading !== 3'd0 || busy !== 1'b0 || bcount !== 32'd0 || rvalid !== 1'b0 || rdo !== 8'h00) begin
         errors++;
         $display("FAIL rst_mid got loading=%0d busy=%b bc=%0d v=%b do=%h want 0 0 0 0 00",
                  loading, busy, bcount, rvalid, rdo);
      end
      reset = 1'b0;
      exp_n.delete();
      repeat (40) @(negedge clk);
      checks++;
      if (obs_n.size() != 0) begin
         errors++;
         $display("FAIL rst_no_beats got %0d beats want 0", obs_n.size());
      end
      cpu_data(1'b0, 32'hFFFFFFFF, 4'hF);
      repeat (20) @(negedge clk);
      checks++;
      if (busy !== 1'b0 || obs_n.size() != 0) begin
         errors++;
         $display("FAIL rst_discard got busy=%b beats=%0d want 0 0", busy, obs_n.size());
      end
   endtask

   initial begin
      reset = 1'b1;
      data_we = 1'b0; data_di = '0; data_wstrb = '0; ctrl_we = 1'b0; ctrl_di = '0; ready = 1'b1;
      w_data_we = 1'b0; w_data_di = '0; w_data_wstrb = '0; w_ctrl_we = 1'b0; w_ctrl_di = '0;
      w_ready = 1'b1;
      @(negedge clk);
      test_reset();
      test_single();
      test_backpressure();
      test_back_to_back();
      test_ctrl_drain();
      test_wide();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/rom_stream_loader.md
# rom_stream_loader

Parametrised successor to the iosys ROM-loading register pair (ctrl at 0x0200_0030, data at 0x0200_0034). It takes 32-bit words written by the PicoRV32 softcore, buffers them in a FIFO, and serialises them to the core at a configurable beat width and pacing. Unlike the single-word loader it adds:
- consumer backpressure;
- partial final words;
- drain-before-mode-change semantics;
- a running byte counter.

It sits between the iosys memory-mapped register decode and the core's cartridge/BIOS loader.

## Interface
Parameters:
- OUT_W, 8: output beat width in bits; legal values 8 or 16.
- DEPTH, 4: FIFO depth in 32-bit words; power of two, ≥2.
- DELAY, 12: minimum cycles between beats; ≥1.

Ports:
- clk  in  1  system clock; single clock domain (already decided).
- reset  in  1  synchronous, active-high (already decided).
- reg_data_we  in  1  CPU write to data register.
- reg_data_di  in  32  write data; byte 0 in bits 7:0 is emitted first.
- reg_data_wstrb  in  4  byte strobes. Valid byte count = (index of highest set bit)+1; lanes below it are emitted even if their strobe is clear.
- reg_data_wait  out  1  stall the CPU; high while FIFO full and rom_loading≠0.
- reg_ctrl_we  in  1  CPU write to control register.
- reg_ctrl_di  in  3  requested loading mode (0 idle, 1 ROM, 2 cart RAM, 3 config, 4 BIOS).
- reg_ctrl_wait  out  1  stall the CPU; high while busy.
- rom_loading  out  3  current mode.
- rom_do  out  OUT_W  beat data.
- rom_be  out  OUT_W/8  byte enables of the beat.
- rom_do_valid  out  1  one-cycle beat strobe.
- rom_ready  in  1  consumer can accept a beat this cycle.
- busy  out  1  FIFO non-empty or serializer holding bytes.
- byte_count  out  32  bytes emitted since last ctrl write; wraps mod 2^32.

## Operation
- FIFO: stores {data, nbytes[2:0]}. Push on reg_data_we && |wstrb && !reg_data_wait && rom_loading≠0.
  - A write with wstrb==0 is ignored without stalling.
  - Data writes while rom_loading==0 are discarded without stalling.
  - No same-cycle bypass when full: wait stays high until a pop has occurred on an earlier cycle.
- Serializer states:
  - IDLE: when FIFO non-empty, pop into shift register and go to EMIT.
  - EMIT: beat fires when rom_ready && delay_cnt==0. Each beat:
    - shifts out OUT_W bits;
    - decrements remaining bytes by OUT_W/8, saturating at 0;
    - reloads delay_cnt with DELAY-1.
  - On the last beat of a word: if the FIFO is non-empty, pop the next word in the same cycle and stay in EMIT; otherwise go to IDLE.
- OUT_W=16 with odd remaining bytes: final beat has rom_be=2'b01 and upper byte 0.
- rom_be on 8-bit beats is always 1.
- byte_count adds popcount(rom_be) on every beat.
- Ctrl write, accepted when !busy:
  - rom_loading ← reg_ctrl_di on the next cycle;
  - byte_count ← 0 on the next cycle.
  - While busy, reg_ctrl_wait holds the CPU until drain completes, so a mode change never truncates data.
- delay_cnt decrements to 0 independently of rom_ready. A held-off beat fires in the first cycle rom_ready rises.
- Reset: flushes the FIFO and serializer, and clears the counters.

## Timing
- Reset values: rom_loading=0, rom_do=0, rom_be=0, rom_do_valid=0, reg_data_wait=0, reg_ctrl_wait=0, busy=0, byte_count=0, delay_cnt=0.
- Write→first beat latency: the write is accepted in cycle t. It is in the FIFO at t+1, loaded into the serializer at t+1, and the first beat is at t+2 if rom_ready and delay_cnt==0.
- Steady state with rom_ready high: one beat every DELAY cycles. A full word takes 4·DELAY cycles (OUT_W=8) or 2·DELAY cycles (OUT_W=16), with no gap between words.
- busy falls in the cycle after the last beat. reg_ctrl_wait follows busy combinationally.
- rom_do/rom_be are registered; they are valid only while rom_do_valid=1 and hold their value otherwise.
- Reset asserted mid-word: all outputs reach their reset values on the next clock edge; no further rom_do_valid.

## Test plan
- Write mode 1, then data 0x44332211 with wstrb 1111 (OUT_W=8, DELAY=12, rom_ready=1) -> beats 0x11, 0x22, 0x33, 0x44 at cycles t+2, +14, +26, +38; byte_count=4; busy falls at t+39.
- OUT_W=16: write 0xCCBBAA99 wstrb 1111, then 0x00000077 wstrb 0001 -> beats 0xAA99, 0xCCBB, then 0x0077 with rom_be=01; byte_count=5.
- DEPTH=4: issue 6 back-to-back writes -> reg_data_wait asserts after the 5th word enters (4 in FIFO plus 1 in serializer); all 24 bytes emitted in order; none lost.
- Hold rom_ready=0 for 50 cycles mid-word -> no rom_do_valid during the hold; the next beat is on the first cycle rom_ready=1; data order unchanged.
- Ctrl write of 0 while 2 words pending -> reg_ctrl_wait high until the last beat; rom_loading goes 0 the cycle after acceptance; byte_count reset to 0.
- Assert reset during the 2nd beat -> next cycle rom_loading=0, busy=0, byte_count=0; a subsequent data write with mode 0 is discarded.
